// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32 ALU, load, store and BEQ instructions into
// operands and control, and queues them in a small FIFO that feeds execute.
// Unsupported encodings are consumed, then dropped, and counted.
module alu_issue_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic [3:0]       alu_control,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             is_branch,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CW      = PTR_W + 1;
    localparam int ENTRY_W = 77;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;

    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_in2;
    logic [4:0]  dec_rd;
    logic        dec_rw;
    logic        dec_mr;
    logic        dec_mw;
    logic        dec_br;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;

    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Register indices reach us only through rs1_data/rs2_data.
    logic unused_rs_fields;
    assign unused_rs_fields = ^instr[19:15];

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

    // Combinational decode of the presented instruction.
    always_comb begin
        dec_legal = 1'b0;
        dec_ctrl  = CTRL_ADD;
        dec_in2   = rs2_data;
        dec_rd    = instr[11:7];
        dec_rw    = 1'b0;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_br    = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_rw = 1'b1;
                if (f3 == 3'b000 && f7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_ADD;
                end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_SUB;
                end else if (f3 == 3'b111 && f7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_AND;
                end else if (f3 == 3'b110 && f7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_OR;
                end
            end
            7'b0010011: begin
                dec_rw  = 1'b1;
                dec_in2 = imm_i;
                if (f3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_ADD;
                end else if (f3 == 3'b111) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_AND;
                end else if (f3 == 3'b110) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_OR;
                end
            end
            7'b0000011: begin
                dec_legal = (f3 == 3'b010);
                dec_in2   = imm_i;
                dec_rw    = 1'b1;
                dec_mr    = 1'b1;
            end
            7'b0100011: begin
                dec_legal = (f3 == 3'b010);
                dec_in2   = imm_s;
                dec_mw    = 1'b1;
                dec_rd    = 5'd0;
            end
            7'b1100011: begin
                dec_legal = (f3 == 3'b000);
                dec_ctrl  = CTRL_SUB;
                dec_br    = 1'b1;
                dec_rd    = 5'd0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready && !flush;
    assign push      = accept && dec_legal;
    assign pop       = out_valid && out_ready && !flush;

    // FIFO pointers, occupancy and illegal tracking; flush overrides everything.
    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_d     = 1'b0;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {rs1_data, dec_in2, dec_ctrl, dec_rd,
                                   dec_rw, dec_mr, dec_mw, dec_br};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (accept && !dec_legal) begin
                illegal_d = 1'b1;
                if (illegal_cnt_q != {CNT_W{1'b1}}) begin
                    illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign alu_in1     = head[76:45];
    assign alu_in2     = head[44:13];
    assign alu_control = head[12:9];
    assign rd          = head[8:4];
    assign reg_write   = head[3];
    assign mem_read    = head[2];
    assign mem_write   = head[1];
    assign is_branch   = head[0];
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_issue_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .rd          (rd),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .is_branch   (is_branch),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in1", alu_in1, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_cnt", illegal_cnt, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // ADD x3,x1,x2
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs1_data  = 32'd5;
        rs2_data  = 32'd7;
        tick;
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_in1", alu_in1, 5);
        chk("add_in2", alu_in2, 7);
        chk("add_ctrl", alu_control, 4'b0010);
        chk("add_rd", rd, 3);
        chk("add_rw", reg_write, 1);
        tick;
        chk("add_drained", out_valid, 0);
        chk("idle_payload_zero", alu_in2, 0);

        // SW x2,-4(x1) followed back-to-back by BEQ
        in_valid = 1'b1;
        instr    = 32'hFE20AE23;
        rs1_data = 32'h100;
        rs2_data = 32'h55;
        tick;
        chk("sw_valid", out_valid, 1);
        chk("sw_in1", alu_in1, 32'h100);
        chk("sw_in2", alu_in2, 32'hFFFFFFFC);
        chk("sw_ctrl", alu_control, 4'b0010);
        chk("sw_mw", mem_write, 1);
        chk("sw_rw", reg_write, 0);
        chk("sw_rd", rd, 0);
        instr    = 32'h00208463;
        rs1_data = 32'h9;
        rs2_data = 32'h9;
        tick;
        in_valid = 1'b0;
        chk("beq_valid", out_valid, 1);
        chk("beq_ctrl", alu_control, 4'b0110);
        chk("beq_br", is_branch, 1);
        chk("beq_in2", alu_in2, 9);
        chk("beq_rd", rd, 0);
        chk("beq_mw", mem_write, 0);
        tick;
        chk("beq_drained", out_valid, 0);

        // Fill to full with out_ready low, then drain in order
        out_ready = 1'b0;
        rs1_data  = 32'h11;
        rs2_data  = 32'h0;
        in_valid  = 1'b1;
        instr     = 32'h00508213;   // ADDI x4,x1,5
        tick;
        chk("fill1_ready", in_ready, 1);
        instr = 32'hFFF0E293;       // ORI x5,x1,-1
        tick;
        chk("fill2_ready", in_ready, 0);
        chk("fill2_head_rd", rd, 4);
        chk("fill2_head_in2", alu_in2, 5);
        chk("fill2_head_in1", alu_in1, 32'h11);
        instr = 32'h0F00F313;       // ANDI x6,x1,0xF0
        tick;
        chk("full_hold_ready", in_ready, 0);
        chk("full_hold_rd", rd, 4);
        out_ready = 1'b1;
        tick;
        chk("pop1_ready", in_ready, 1);
        chk("pop1_rd", rd, 5);
        chk("pop1_in2", alu_in2, 32'hFFFFFFFF);
        chk("pop1_ctrl", alu_control, 4'b0001);
        tick;
        in_valid = 1'b0;
        chk("pop2_rd", rd, 6);
        chk("pop2_ctrl", alu_control, 4'b0000);
        chk("pop2_in2", alu_in2, 32'hF0);
        chk("pop2_valid", out_valid, 1);
        tick;
        chk("fill_drained", out_valid, 0);

        // Flush with two ops buffered and an AND presented
        out_ready = 1'b0;
        rs1_data  = 32'h3;
        rs2_data  = 32'h1;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;   // ADD
        tick;
        instr = 32'h402081B3;       // SUB
        tick;
        chk("preflush_full", in_ready, 0);
        instr = 32'h0020F3B3;       // AND x7,x1,x2
        flush = 1'b1;
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        out_ready = 1'b1;
        tick;
        chk("flush_and_dropped", out_valid, 0);

        // Flush while empty: legal and illegal instructions both dropped
        in_valid = 1'b1;
        flush    = 1'b1;
        instr    = 32'h0020F3B3;
        tick;
        chk("flush_empty_valid", out_valid, 0);
        instr = 32'hFFFFFFFF;
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_illegal_pulse", illegal, 0);
        chk("flush_illegal_cnt", illegal_cnt, 0);

        // Illegal stream: MUL-like encoding, then all-ones until saturation
        in_valid = 1'b1;
        instr    = 32'h022081B3;
        tick;
        chk("ill_mul_pulse", illegal, 1);
        chk("ill_mul_cnt", illegal_cnt, 1);
        chk("ill_mul_valid", out_valid, 0);
        instr   = 32'hFFFFFFFF;
        exp_cnt = 1;
        for (int i = 0; i < 301; i++) begin
            tick;
            if (exp_cnt < 255) exp_cnt++;
            chk("ill_stream_cnt", illegal_cnt, exp_cnt);
            chk("ill_stream_pulse", illegal, 1);
        end
        in_valid = 1'b0;
        chk("ill_sat_cnt", illegal_cnt, 255);
        chk("ill_sat_valid", out_valid, 0);
        tick;
        chk("ill_pulse_end", illegal, 0);
        chk("ill_cnt_hold", illegal_cnt, 255);

        // Asynchronous reset between clock edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs1_data  = 32'h77;
        rs2_data  = 32'h1;
        tick;
        in_valid = 1'b0;
        chk("prereset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_in1", alu_in1, 0);
        chk("arst_ctrl", alu_control, 0);
        chk("arst_rw", reg_write, 0);
        chk("arst_cnt", illegal_cnt, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_reset_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU operand and control interface: in1, in2, and the 4-bit alu_control.
- Accepts decoded-fetch instructions plus register-file read data over a valid/ready handshake.
- Decodes each instruction into ALU operands and control, and buffers issued ops in a small FIFO ahead of the execute stage.
- Detects unsupported encodings, drops them and counts them.

Parameters:
- DEPTH, 2, issue FIFO entries; power of two, >= 2.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage can accept; high when FIFO not full.
- instr  in  32  RV32 instruction word.
- rs1_data  in  32  register-file value for instr[19:15].
- rs2_data  in  32  register-file value for instr[24:20].
- flush  in  1  discard all buffered ops and any op presented this cycle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute stage consumes head.
- alu_in1  out  32  operand 1 (always rs1_data).
- alu_in2  out  32  operand 2 (rs2_data or sign-extended immediate).
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- rd  out  5  destination register.
- reg_write  out  1  result written back.
- mem_read  out  1  load.
- mem_write  out  1  store.
- is_branch  out  1  BEQ; execute uses zero_flag.
- illegal  out  1  one-cycle pulse, cycle after an illegal instr is accepted.
- illegal_cnt  out  CNT_W  saturating count of illegal instrs.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, out_valid=0, in_ready=1, all payload outputs 0, illegal=0, illegal_cnt=0.
- Accept: transfer occurs when in_valid && in_ready && !flush. Decode is combinational on instr; the decoded entry is written to the FIFO tail at the clock edge.
- Decode, with opcode=instr[6:0], f3=instr[14:12], f7=instr[31:25]:
  - 0110011, f3=000, f7=0000000: ADD, in2=rs2, reg_write.
  - 0110011, f3=000, f7=0100000: SUB, in2=rs2, reg_write.
  - 0110011, f3=111, f7=0: AND. f3=110, f7=0: OR. Both in2=rs2, reg_write.
  - 0010011, f3=000/111/110: ADDI/ANDI/ORI, in2=sext(instr[31:20]), reg_write.
  - 0000011, f3=010 (LW): ADD, in2=sext(instr[31:20]), reg_write, mem_read.
  - 0100011, f3=010 (SW): ADD, in2=sext({instr[31:25],instr[11:7]}), mem_write, rd=0.
  - 1100011, f3=000 (BEQ): SUB, in2=rs2, is_branch, rd=0.
  - Anything else is illegal.
- Illegal op: the handshake completes (consumed) but nothing is enqueued. illegal pulses high for one cycle on the next cycle. illegal_cnt increments and saturates at all-ones.
- Latency: a legal op accepted into an empty FIFO appears at out_valid on the next cycle.
- Throughput: one op per cycle with out_ready held high.
- Outputs: registered/head-driven. Payload outputs equal the head entry when out_valid=1 and are forced to 0 when out_valid=0.
- Pop: on out_valid && out_ready.
- Simultaneous push and pop: allowed whenever not full; occupancy unchanged.
- Full: in_ready=0 until a pop occurs; in_ready rises in the cycle after the pop edge (derived from registered count).
- Pointers wrap modulo DEPTH.
- flush (synchronous, highest priority):
  - Next cycle: FIFO empty, out_valid=0, in_ready=1.
  - The instr presented in the flush cycle is dropped, including illegal detection (no pulse, no count).
  - A pop in the flush cycle is irrelevant.
  - illegal_cnt is not cleared by flush.
- Reset mid-operation: immediate return to the reset state; in-flight entries are lost.

Test Plan:
- Reset, then ADD x3,x1,x2 (instr 0x002081B3, rs1=5, rs2=7) with out_ready=1 -> next cycle out_valid=1, in1=5, in2=7, alu_control=0010, rd=3, reg_write=1.
- SW x2,-4(x1) (0xFE20AE23), rs1=0x100 -> alu_control=0010, in2=0xFFFFFFFC, mem_write=1, reg_write=0. BEQ (0x00208463) -> alu_control=0110, is_branch=1.
- out_ready=0, push 3 legal ops with DEPTH=2 -> in_ready=0 after 2 accepts. Raise out_ready -> ops drain in order, third accepted after the first pop, no loss or duplication.
- Instr 0xFFFFFFFF, then 300 more illegal instrs -> illegal pulses each accept; illegal_cnt saturates at 255; FIFO stays empty.
- FIFO holding 2 ops, assert flush with a valid AND instr present -> next cycle out_valid=0, in_ready=1, AND never issued.
- Deassert rst_n asynchronously mid-stream between clock edges -> outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
